fir_mac_sequencer: RTL and testbench
====================================

Name: fir_mac_sequencer

Overview:
- Time-multiplexed FIR tap sequencer and accumulator.
- Sits around one shared combinational signed multiplier (M x M -> N).
- Holds the sample history and the coefficient table, drives one (sample, coefficient) pair per cycle into the multiplier, and sign-extends and accumulates the returned products.
- Presents one filtered output per accepted input sample on a valid/ready handshake.

Parameters:
- M, 16, sample and coefficient width (signed two's complement).
- N, 32, multiplier product width (signed).
- TAPS, 8, filter length; power of two, minimum 2.
- ACC_W, N+$clog2(TAPS) (35 at defaults), accumulator and output width (signed).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input sample valid.
- in_ready  out  1  block can accept a sample.
- in_data  in  M  signed input sample x[n].
- coef_we  in  1  coefficient write strobe.
- coef_addr  in  $clog2(TAPS)  coefficient index k.
- coef_data  in  M  signed coefficient h[k].
- mul_a  out  M  sample operand to the multiplier.
- mul_b  out  M  coefficient operand to the multiplier.
- mul_res  in  N  signed product of mul_a*mul_b, same cycle (combinational multiplier).
- out_valid  out  1  output result valid.
- out_ready  in  1  downstream accepts the result.
- out_data  out  ACC_W  signed y[n] = sum over k=0..TAPS-1 of h[k]*x[n-k].

Behaviour:
- Reset (rst=1 at an edge): state goes to IDLE.
  - History buffer and coefficient table all zero.
  - Write pointer = 0, tap index = 0, accumulator = 0.
  - out_valid=0, out_data=0, in_ready=1, mul_a=0, mul_b=0.
  - Reset mid-RUN or mid-DONE abandons the result; the next output is computed from the zeroed history.
- States:
  - IDLE: in_ready=1, mul_a/mul_b=0.
    - On in_valid=1 at an edge: write in_data into history[wptr], latch base=wptr, then increment wptr (wraps mod TAPS).
    - Clear accumulator, set k=0, go to RUN.
  - RUN: in_ready=0.
    - mul_a = history[(base-k) mod TAPS], mul_b = coef[k], both combinational from registered state.
    - Each edge: acc <= acc + sign_extend(mul_res to ACC_W), k <= k+1.
    - At k=TAPS-1: out_data <= acc + sign_extend(mul_res), go to DONE.
  - DONE: out_valid=1, in_ready=0, mul_a/mul_b=0; out_data held stable.
    - On out_ready=1 at an edge: out_valid <= 0, go to IDLE.
- Latency and throughput:
  - out_valid rises TAPS edges after the accepting edge.
  - Minimum sample period is TAPS+2 cycles (accept, TAPS RUN cycles, DONE handshake).
- Arithmetic:
  - Pure signed two's complement.
  - ACC_W is sized so TAPS full-scale products cannot overflow; no saturation or rounding.
  - Any out-of-range sum wraps mod 2^ACC_W.
- Coefficient writes:
  - Honoured only in IDLE; coef_we in RUN/DONE is ignored.
  - coef_we and an accepted in_valid on the same IDLE edge: both take effect, and the new coefficient is used for that sample.
- in_valid outside IDLE is ignored (not queued). Upstream must hold in_valid until in_ready.
- History wraps circularly. After more than TAPS samples, the oldest sample is overwritten.

Test Plan:
- Reset: assert rst 2 cycles mid-stream -> out_valid=0, out_data=0, in_ready=1, mul_a=mul_b=0 on the edge after reset; next impulse response starts from zero history.
- Impulse: coef[k]=k+1 (k=0..7), out_ready=1, feed samples 1,0,0,0,0,0,0,0 -> out_data sequence 1,2,3,4,5,6,7,8; out_valid 8 edges after each accept; sample period 10 cycles.
- Signed extremes: all coef=-32768, feed eight -32768 samples -> 8th output = 8589934592 (35'h2_0000_0000); with coef=-32768 and samples +32767 -> 8th output = -8589672448.
- Backpressure: hold out_ready=0 for 5 cycles in DONE, toggle in_valid and coef_we meanwhile -> out_data stable, in_ready=0, no sample accepted, coefficients unchanged.
- Wrap-around: all coef=1, feed samples 1..10 -> outputs 1,3,6,10,15,21,28,36,44,52.
- Same-edge coef write + accept: coef all 0, in IDLE write coef[0]=5 on the same edge as in_valid with sample 3 -> out_data=15.

Source files
------------

// File: rtl/fir_mac_sequencer.sv
// ============================================================================
// Module   : fir_mac_sequencer
// Purpose  : Time-multiplexed FIR tap sequencer/accumulator around one shared
//            combinational signed multiplier.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fir_mac_sequencer #(
  parameter int M     = 16,
  parameter int N     = 32,
  parameter int TAPS  = 8,
  parameter int ACC_W = N + $clog2(TAPS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [M-1:0]     in_data,
  input  logic                    coef_we,
  input  logic [$clog2(TAPS)-1:0] coef_addr,
  input  logic signed [M-1:0]     coef_data,
  output logic signed [M-1:0]     mul_a,
  output logic signed [M-1:0]     mul_b,
  input  logic signed [N-1:0]     mul_res,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [ACC_W-1:0] out_data
);

  localparam int c_AW = $clog2(TAPS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t r_state, w_next;

  logic signed [M-1:0]     r_hist [TAPS];
  logic signed [M-1:0]     r_coef [TAPS];
  logic [c_AW-1:0]         r_wptr, r_base, r_k, w_idx;
  logic signed [ACC_W-1:0] r_acc, r_out_data, w_prod, w_sum;
  logic                    w_last;

  // Tap k pairs with x[n-k]; the pointer arithmetic wraps at TAPS for free.
  assign w_idx    = r_base - r_k;
  assign w_last   = (r_k == c_AW'(TAPS - 1));
  assign w_prod   = ACC_W'(mul_res);
  assign w_sum    = r_acc + w_prod;
  assign out_data = r_out_data;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    mul_a     = '0;
    mul_b     = '0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_next = RUN;
      end
      RUN: begin
        mul_a = r_hist[w_idx];
        mul_b = r_coef[r_k];
        if (w_last) w_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < TAPS; i++) begin
        r_hist[i] <= '0;
        r_coef[i] <= '0;
      end
      r_wptr     <= '0;
      r_base     <= '0;
      r_k        <= '0;
      r_acc      <= '0;
      r_out_data <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          // A same-edge coefficient write lands before the first RUN read.
          if (coef_we) r_coef[coef_addr] <= coef_data;
          if (in_valid) begin
            r_hist[r_wptr] <= in_data;
            r_base         <= r_wptr;
            r_wptr         <= r_wptr + 1'b1;
            r_acc          <= '0;
            r_k            <= '0;
          end
        end
        RUN: begin
          r_acc <= w_sum;
          r_k   <= r_k + 1'b1;
          if (w_last) r_out_data <= w_sum;
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fir_mac_sequencer.sv
// ============================================================================
// Module   : tb_fir_mac_sequencer
// Purpose  : Directed scoreboard bench for fir_mac_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fir_mac_sequencer;

  localparam int c_M    = 16;
  localparam int c_N    = 32;
  localparam int c_TAPS = 8;
  localparam int c_ACCW = 35;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic                     in_valid = 1'b0;
  logic                     in_ready;
  logic signed [c_M-1:0]    in_data = '0;
  logic                     coef_we = 1'b0;
  logic [2:0]               coef_addr = '0;
  logic signed [c_M-1:0]    coef_data = '0;
  logic signed [c_M-1:0]    mul_a, mul_b;
  logic signed [c_N-1:0]    mul_res;
  logic                     out_valid;
  logic                     out_ready = 1'b1;
  logic signed [c_ACCW-1:0] out_data;

  int total = 0;
  int bad   = 0;

  // Reference model state and scoreboard
  logic signed [c_M-1:0]    m_hist [c_TAPS];
  logic signed [c_M-1:0]    m_coef [c_TAPS];
  int                       m_wptr;
  logic signed [c_ACCW-1:0] sb [$];
  logic signed [c_ACCW-1:0] last_exp;

  always #5 clk = ~clk;

  assign mul_res = mul_a * mul_b;

  fir_mac_sequencer #(.M(c_M), .N(c_N), .TAPS(c_TAPS)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .mul_a(mul_a), .mul_b(mul_b), .mul_res(mul_res),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  task automatic chk(input string tag, input longint obs, input longint exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < c_TAPS; i++) begin
      m_hist[i] = '0;
      m_coef[i] = '0;
    end
    m_wptr = 0;
    sb.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    coef_we = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_mul_a", mul_a, 0);
    chk("rst_mul_b", mul_b, 0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic wr_coef(input int k, input int v);
    @(negedge clk);
    coef_we = 1'b1;
    coef_addr = 3'(k);
    coef_data = 16'(v);
    @(posedge clk);
    #1;
    coef_we = 1'b0;
    m_coef[k] = 16'(v);
  endtask

  task automatic set_all_coef(input int v);
    for (int k = 0; k < c_TAPS; k++) wr_coef(k, v);
  endtask

  // Accept one sample (optionally with a same-edge coef write), predict its
  // output, then check latency and value when out_valid appears.
  task automatic feed(input int x, input bit hold, input bit cw, input int ca, input int cv);
    longint s;
    int     n;
    bit     seen;
    @(negedge clk);
    in_valid = 1'b1;
    in_data = 16'(x);
    coef_we = cw;
    coef_addr = 3'(ca);
    coef_data = 16'(cv);
    chk("idle_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    coef_we = 1'b0;
    if (cw) m_coef[ca] = 16'(cv);
    m_hist[m_wptr] = 16'(x);
    s = 0;
    for (int k = 0; k < c_TAPS; k++)
      s += longint'(m_hist[(m_wptr - k) & (c_TAPS - 1)]) * longint'(m_coef[k]);
    m_wptr = (m_wptr + 1) % c_TAPS;
    sb.push_back(c_ACCW'(s));
    chk("busy_in_ready", in_ready, 0);
    n = 0;
    seen = 1'b0;
    while (!seen && n < 20) begin
      @(posedge clk);
      #1;
      n++;
      seen = out_valid;
    end
    chk("latency", n, c_TAPS);
    if (!seen) return;
    last_exp = sb.pop_front();
    chk("out_data", out_data, last_exp);
    if (!hold) begin
      @(posedge clk);
      #1;
      chk("handshake_out_valid", out_valid, 0);
    end
  endtask

  initial begin
    model_reset();
    do_reset();

    // Impulse response reads the coefficient table back
    for (int k = 0; k < c_TAPS; k++) wr_coef(k, k + 1);
    feed(1, 0, 0, 0, 0);
    chk("impulse_first", last_exp, 1);
    for (int i = 1; i < c_TAPS; i++) feed(0, 0, 0, 0, 0);
    chk("impulse_last", last_exp, 8);

    // Signed extremes
    set_all_coef(-32768);
    for (int i = 0; i < c_TAPS; i++) feed(-32768, 0, 0, 0, 0);
    chk("max_pos_const", last_exp, 64'sd8589934592);
    for (int i = 0; i < c_TAPS; i++) feed(32767, 0, 0, 0, 0);
    chk("max_neg_const", last_exp, -64'sd8589672448);

    // Backpressure: output held, inputs and coef writes ignored
    feed(5, 1, 0, 0, 0);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = ~in_valid;
      in_data = 16'sd1234;
      coef_we = 1'b1;
      coef_addr = 3'(i);
      coef_data = 16'sd99;
      @(posedge clk);
      #1;
      chk("bp_out_data", out_data, last_exp);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    coef_we = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_release", out_valid, 0);
    feed(2, 0, 0, 0, 0);
    feed(-3, 0, 0, 0, 0);

    // Reset in the middle of a computation
    @(negedge clk);
    in_valid = 1'b1;
    in_data = 16'sd7;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    do_reset();
    for (int k = 0; k < c_TAPS; k++) wr_coef(k, k + 1);
    feed(1, 0, 0, 0, 0);
    chk("post_rst_first", last_exp, 1);
    feed(0, 0, 0, 0, 0);

    // Circular history wrap
    do_reset();
    set_all_coef(1);
    for (int i = 1; i <= 10; i++) feed(i, 0, 0, 0, 0);
    chk("wrap_last", last_exp, 52);

    // Same-edge coefficient write and sample accept
    do_reset();
    feed(3, 0, 1, 0, 5);
    chk("same_edge_const", last_exp, 15);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
